// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the VeriRisc phase sequencer: opcodes, phase encoding and
// the ALU-opcode membership helper.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

    // Opcodes whose result comes back through the ALU into the accumulator.
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer for VeriRisc with sticky halt/resume, global
// enable and a saturating retired-instruction counter.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             resume,
    input  opcode_t          opcode,
    input  logic             zero,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_ac,
    output logic             halt,
    output state_t           phase,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t             phase_q, phase_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               aluop;

    assign aluop = is_aluop(opcode);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        load_ir  = 1'b0;
        inc_pc   = 1'b0;
        load_pc  = 1'b0;
        load_ac  = 1'b0;

        // While halted the phase stays parked at OP_FETCH; resume works even with enable low.
        if (halted_q) begin
            if (resume) begin
                halted_d = 1'b0;
            end
        end else if (enable) begin
            phase_d = state_t'(phase_q + 3'd1);
            if (phase_q == OP_ADDR && opcode == HLT) begin
                halted_d = 1'b1;
            end
            if (phase_q == STORE && cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (!halted_q) begin
            unique case (phase_q)
                INST_ADDR: ;
                INST_FETCH: mem_rd = 1'b1;
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: inc_pc = 1'b1;
                OP_FETCH: mem_rd = aluop;
                ALU_OP: begin
                    mem_rd  = aluop;
                    inc_pc  = (opcode == SKZ) && zero;
                    load_pc = (opcode == JMP);
                end
                STORE: begin
                    mem_rd  = aluop;
                    inc_pc  = (opcode == JMP);
                    load_pc = (opcode == JMP);
                    load_ac = aluop;
                    mem_wr  = (opcode == STO);
                end
                default: ;
            endcase
        end
    end

    assign halt      = halted_q;
    assign phase     = phase_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed test-plan steps followed by
// randomized traffic, all compared against a phase-table reference model.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam int unsigned CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, enable, resume, zero;
    opcode_t       opcode;
    logic          mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt;
    state_t        phase;
    logic [CW-1:0] instr_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state: phase number, halted flag, retired count.
    int m_ph  = 0;
    bit m_h   = 0;
    int m_cnt = 0;

    cpu_sequencer #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .resume    (resume),
        .opcode    (opcode),
        .zero      (zero),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .load_ir   (load_ir),
        .inc_pc    (inc_pc),
        .load_pc   (load_pc),
        .load_ac   (load_ac),
        .halt      (halt),
        .phase     (phase),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    // Strobe vector {mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac} from the phase table.
    function automatic logic [5:0] exp_strobes(input int ph, input bit h, input int op,
                                               input bit z);
        bit alu;
        bit rd, wr, ir, ipc, lpc, lac;
        alu = (op >= 2) && (op <= 5);
        {rd, wr, ir, ipc, lpc, lac} = 6'b0;
        if (!h) begin
            case (ph)
                1: rd = 1;
                2, 3: begin rd = 1; ir = 1; end
                4: ipc = 1;
                5: rd = alu;
                6: begin rd = alu; ipc = (op == 1) && z; lpc = (op == 7); end
                7: begin rd = alu; ipc = (op == 7); lpc = (op == 7); lac = alu;
                         wr = (op == 6); end
                default: ;
            endcase
        end
        return {rd, wr, ir, ipc, lpc, lac};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_ph = 0; m_h = 0; m_cnt = 0;
        end else if (m_h) begin
            if (resume) m_h = 0;
        end else if (enable) begin
            if (m_ph == 4 && int'(opcode) == 0) m_h = 1;
            if (m_ph == 7 && m_cnt < CMAX) m_cnt++;
            m_ph = (m_ph + 1) % 8;
        end
    endtask

    task automatic check(input string tag);
        logic [5:0] act, exp;
        act = {mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac};
        exp = exp_strobes(m_ph, m_h, int'(opcode), zero);
        n_checks++;
        assert (3'(phase) === 3'(m_ph)) else begin
            n_fails++;
            $error("FAIL %s phase: got %0d expected %0d", tag, phase, m_ph);
        end
        n_checks++;
        assert (halt === m_h) else begin
            n_fails++;
            $error("FAIL %s halt: got %b expected %b", tag, halt, m_h);
        end
        n_checks++;
        assert (instr_cnt === CW'(m_cnt)) else begin
            n_fails++;
            $error("FAIL %s instr_cnt: got %0d expected %0d", tag, instr_cnt, m_cnt);
        end
        n_checks++;
        assert (act === exp) else begin
            n_fails++;
            $error("FAIL %s strobes(rd,wr,ir,ipc,lpc,lac): got %b expected %b (ph=%0d op=%0d z=%b)",
                   tag, act, exp, m_ph, int'(opcode), zero);
        end
    endtask

    // Apply the current inputs to one edge, then compare shortly after it.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic expect_val(input string tag, input int got, input int want);
        n_checks++;
        assert (got === want) else begin
            n_fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    initial begin
        rst = 1; enable = 0; resume = 0; opcode = LDA; zero = 0;
        tick("reset");
        expect_val("reset_phase", int'(phase), 0);
        expect_val("reset_strobes", int'({mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac}), 0);
        rst = 0; enable = 1;

        run(8, "lda");
        expect_val("lda_cnt", int'(instr_cnt), 1);
        opcode = STO; run(8, "sto");
        opcode = SKZ; zero = 1; run(8, "skz_z1");
        zero = 0; run(8, "skz_z0");
        opcode = JMP; run(8, "jmp");

        opcode = HLT; run(5, "hlt_enter");
        expect_val("hlt_halt", int'(halt), 1);
        run(20, "hlt_hold");
        expect_val("hlt_phase", int'(phase), 5);
        resume = 1; tick("hlt_resume");
        resume = 0; run(3, "hlt_finish");
        expect_val("hlt_cnt", int'(instr_cnt), 6);

        opcode = LDA; run(6, "pre_rst");
        rst = 1; tick("mid_rst");
        rst = 0;
        expect_val("mid_rst_cnt", int'(instr_cnt), 0);

        run(3, "to_idle");
        enable = 0; run(5, "en_low");
        expect_val("en_low_ld_ir", int'(load_ir), 1);
        enable = 1; run(5, "en_high");

        // Halt with enable low: resume must still be accepted.
        opcode = HLT; run(8, "hlt2");
        enable = 0; resume = 1; tick("hlt2_resume_en0");
        resume = 0; enable = 1; run(3, "hlt2_finish");

        for (int i = 0; i < 600; i++) begin
            if (m_ph == 0 && !m_h) opcode = opcode_t'($urandom_range(0, 7));
            zero   = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 3) != 0);
            resume = ($urandom_range(0, 5) == 0);
            rst    = ($urandom_range(0, 199) == 0);
            tick("rand");
        end
        rst = 0; resume = 0; enable = 1;

        rst = 1; tick("sat_rst");
        rst = 0; opcode = LDA;
        run(8 * (CMAX + 3), "sat");
        expect_val("sat_cnt", int'(instr_cnt), CMAX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Phase sequencer for the VeriRisc CPU.
- Drives the ALU and the rest of the datapath: steps an 8-phase instruction cycle, reads the opcode and the ALU zero flag, and issues memory, PC, IR and accumulator strobes.
- Adds a sticky halt with resume, a global enable, and a retired-instruction counter for bench observability.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  input  1  system clock; phase register updates on posedge
- rst  input  1  synchronous, active-high reset
- enable  input  1  when 0, phase and counter hold; outputs still decode from the held phase
- resume  input  1  single-cycle pulse; leaves HALTED
- opcode  input  opcode_t (3)  current instruction opcode from the IR
- zero  input  1  ALU zero flag (accum == 0)
- mem_rd  output  1  memory read strobe
- mem_wr  output  1  memory write strobe
- load_ir  output  1  load instruction register
- inc_pc  output  1  increment program counter
- load_pc  output  1  load PC from IR operand field
- load_ac  output  1  load accumulator from ALU out
- halt  output  1  CPU halted
- phase  output  state_t (3)  current phase, for debug
- instr_cnt  output  CNT_W  retired instructions, saturating

Behaviour:
- Clocking and reset: single clock domain. Synchronous active-high reset, clk and rst as named. On rst at posedge:
  - phase = INST_ADDR, halted = 0, instr_cnt = 0.
  - Hence all strobes = 0 and halt = 0 in the cycle after reset.
  - rst mid-instruction aborts it; no strobe is emitted in the reset cycle's successor.
- Phases: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, encoded 0..7, plus a separate halted flag.
- Transitions:
  - With enable=1 and halted=0, phase advances one step per clk; STORE wraps to INST_ADDR.
  - With enable=0, everything holds.
- Strobe decode: combinational from phase, opcode and zero. ALUOP = opcode in {ADD, AND, XOR, LDA}.
  - INST_ADDR: all 0.
  - INST_FETCH: mem_rd.
  - INST_LOAD: mem_rd, load_ir.
  - IDLE: mem_rd, load_ir.
  - OP_ADDR: inc_pc. If opcode==HLT, halted is set at the end of this cycle.
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP; inc_pc=(opcode==SKZ && zero); load_pc=(opcode==JMP).
  - STORE: mem_rd=ALUOP; inc_pc=(opcode==JMP); load_pc=(opcode==JMP); load_ac=ALUOP; mem_wr=(opcode==STO).
- Halt:
  - halted=1 freezes phase at OP_FETCH.
  - halt = halted.
  - While halted, all strobes are forced to 0.
  - resume=1 while halted clears halted; phase advances to OP_FETCH's successor normally on the next enabled edge.
  - resume while not halted is ignored.
  - resume and rst together: rst wins.
- Counter: instr_cnt increments by 1 on each enabled STORE→INST_ADDR wrap. It saturates at all-ones. HLT does not count until it completes after resume.
- Opcode and zero are sampled combinationally. The ALU registers on negedge, so zero must be stable before the posedge of ALU_OP. Opcode must not change between IDLE and STORE.
- Undefined opcode values cannot occur (3-bit enum is fully populated).
- Enable low while halted: halted holds; resume is still accepted.

Decomposition:
- typedefs package:
  - Existing opcode_t {HLT=0, SKZ, ADD, AND, XOR, LDA, STO, JMP}.
  - New state_t enum for the eight phases.
  - ALUOP membership helper function.
- No sub-module needed. Single always_ff for the phase, halted and counter registers; single always_comb for decode.
- Bind-able assertions go in a separate checker file, not in the RTL.

Test Plan:
- Reset then 8 enabled clocks with opcode=LDA, zero=0 → phase 0..7 in order; mem_rd high in phases 1,2,3,5,6,7; load_ac only in STORE; instr_cnt=1.
- opcode=STO → mem_wr=1 only in STORE; load_ac=0 throughout; mem_rd=0 in phases 5–7.
- opcode=SKZ with zero=1 → inc_pc in OP_ADDR and ALU_OP (two pulses per instruction); with zero=0 → one pulse.
- opcode=JMP → load_pc=1 in ALU_OP and STORE; inc_pc=1 in STORE.
- opcode=HLT → halt=1 from the cycle after OP_ADDR; phase stays OP_FETCH for 20 cycles with all strobes 0. A resume pulse then completes the instruction, and instr_cnt increments once.
- Mid-cycle rst in ALU_OP → next cycle phase=INST_ADDR, all strobes 0, instr_cnt=0. Also cover enable=0 for 5 cycles in IDLE → phase and counter frozen, mem_rd/load_ir stay asserted.
